// File: rtl/dau_sym_to_ascii_tx_pkg.sv
// Shared DAU symbol codes, ASCII constants and the symbol-to-ASCII mapping
// for the terminal return path.
package dau_sym_to_ascii_tx_pkg;

  localparam int DAU_SYM_WIDTH = 5;

  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_SPACE   = 5'h02;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_R       = 5'h07;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_ENTER   = 5'h0D;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_DIG0    = 5'h10;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_DIG9    = 5'h19;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_MUL     = 5'h1A;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_PLUS    = 5'h1B;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_COMMA   = 5'h1C;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_MINUS   = 5'h1D;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_DIV     = 5'h1E;
  localparam logic [DAU_SYM_WIDTH-1:0] DAU_SYM_INVALID = 5'h1F;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_SEND_LF} tx_state_e;

  typedef struct packed {
    logic       is_valid;
    logic [7:0] chr;
  } sym_map_t;

  // Unmapped codes report is_valid = 0 and carry '?' so the caller can emit it as-is.
  function automatic sym_map_t sym_to_ascii(input logic [DAU_SYM_WIDTH-1:0] sym);
    sym_map_t m;
    m.is_valid = 1'b1;
    m.chr      = ASCII_QMARK;
    if (sym >= DAU_SYM_DIG0 && sym <= DAU_SYM_DIG9) begin
      m.chr = {4'h3, sym[3:0]};
    end else begin
      case (sym)
        DAU_SYM_ENTER: m.chr = ASCII_CR;
        DAU_SYM_SPACE: m.chr = 8'h20;
        DAU_SYM_R:     m.chr = 8'h72;
        DAU_SYM_MUL:   m.chr = 8'h2A;
        DAU_SYM_PLUS:  m.chr = 8'h2B;
        DAU_SYM_COMMA: m.chr = 8'h2C;
        DAU_SYM_MINUS: m.chr = 8'h2D;
        DAU_SYM_DIV:   m.chr = 8'h2F;
        default:       m.is_valid = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/dau_sym_to_ascii_char.sv
// Combinational DAU symbol to ASCII byte lookup.
module dau_sym_to_ascii_char
  import dau_sym_to_ascii_tx_pkg::*;
(
  input  logic [DAU_SYM_WIDTH-1:0] sym_i,
  output logic                     valid_o,
  output logic [7:0]               char_o
);

  sym_map_t map;

  assign map     = sym_to_ascii(sym_i);
  assign valid_o = map.is_valid;
  assign char_o  = map.chr;

endmodule

// File: rtl/dau_sym_to_ascii_tx.sv
// Symbol FIFO plus output FSM turning DAU symbols into ASCII bytes for the UART;
// ENTER expands to CR, LF.
module dau_sym_to_ascii_tx
  import dau_sym_to_ascii_tx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter bit DROP_INVALID = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DAU_SYM_WIDTH-1:0] i_sym,
  input  logic                     i_sym_valid,
  output logic                     o_sym_ready,
  output logic [7:0]               o_char,
  output logic                     o_char_valid,
  input  logic                     i_char_ready,
  output logic                     o_busy
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [DAU_SYM_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [AW:0]              count_q, count_d;
  logic                     push, pop, fifo_empty;

  tx_state_e                state_q, state_d;
  logic [7:0]               char_q, char_d;
  logic                     valid_q, valid_d;
  logic                     enter_q, enter_d;
  logic                     load_next;

  logic [DAU_SYM_WIDTH-1:0] head;
  logic                     head_valid;
  logic [7:0]               head_char;

  assign head        = mem_q[rd_ptr_q];
  assign fifo_empty  = (count_q == '0);
  assign o_sym_ready = (count_q != FULL_CNT);
  assign push        = i_sym_valid && o_sym_ready;

  dau_sym_to_ascii_char u_char (
    .sym_i   (head),
    .valid_o (head_valid),
    .char_o  (head_char)
  );

  always_comb begin
    state_d   = state_q;
    char_d    = char_q;
    valid_d   = valid_q;
    enter_d   = enter_q;
    pop       = 1'b0;
    load_next = 1'b0;
    case (state_q)
      ST_IDLE: load_next = 1'b1;
      ST_SEND: begin
        if (i_char_ready) begin
          if (enter_q) begin
            char_d  = ASCII_LF;
            enter_d = 1'b0;
            state_d = ST_SEND_LF;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      ST_SEND_LF: load_next = i_char_ready;
      default: state_d = ST_IDLE;
    endcase
    // A dropped invalid symbol is popped but leaves the FSM idle for one cycle.
    if (load_next) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      enter_d = 1'b0;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (head_valid || !DROP_INVALID) begin
          char_d  = head_char;
          valid_d = 1'b1;
          enter_d = (head == DAU_SYM_ENTER);
          state_d = ST_SEND;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_sym;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      char_q   <= 8'h00;
      valid_q  <= 1'b0;
      enter_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      state_q <= state_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      enter_q <= enter_d;
    end
  end

  assign o_char       = char_q;
  assign o_char_valid = valid_q;
  assign o_busy       = !fifo_empty || valid_q;

endmodule

// File: tb/tb_dau_sym_to_ascii_tx.sv
// Bench for dau_sym_to_ascii_tx: one instance per DROP_INVALID setting, shared stimulus,
// per-instance byte-stream scoreboard built from the symbol map.
module tb_dau_sym_to_ascii_tx;

  logic       clk, rst;
  logic [4:0] sym;
  logic       sym_valid, char_ready;
  logic       rdy0, cv0, busy0, rdy1, cv1, busy1;
  logic [7:0] chr0, chr1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp0[$], exp1[$], got0[$], got1[$];

  dau_sym_to_ascii_tx #(.FIFO_DEPTH(8), .DROP_INVALID(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_sym(sym), .i_sym_valid(sym_valid), .o_sym_ready(rdy0),
    .o_char(chr0), .o_char_valid(cv0), .i_char_ready(char_ready), .o_busy(busy0));

  dau_sym_to_ascii_tx #(.FIFO_DEPTH(8), .DROP_INVALID(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_sym(sym), .i_sym_valid(sym_valid), .o_sym_ready(rdy1),
    .o_char(chr1), .o_char_valid(cv1), .i_char_ready(char_ready), .o_busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bytes a symbol should produce on the wire; returns how many (0..2).
  function automatic int ref_map(input logic [4:0] s, input bit drop,
                                 output logic [7:0] b0, output logic [7:0] b1);
    string punct = "*+,-/";
    b0 = 8'h3F;
    b1 = 8'h0A;
    if (s >= 5'h10 && s <= 5'h19) begin b0 = 8'h30 + 8'(s - 5'h10); return 1; end
    if (s >= 5'h1A && s <= 5'h1E) begin b0 = punct[s - 5'h1A];      return 1; end
    if (s == 5'h0D) begin b0 = 8'h0D; return 2; end
    if (s == 5'h02) begin b0 = 8'h20; return 1; end
    if (s == 5'h07) begin b0 = 8'h72; return 1; end
    return drop ? 0 : 1;
  endfunction

  int         mn0, mn1;
  logic [7:0] ma0, mb0, ma1, mb1;

  always @(posedge clk) begin
    if (!rst) begin
      if (cv0 && char_ready) got0.push_back(chr0);
      if (cv1 && char_ready) got1.push_back(chr1);
      mn0 = ref_map(sym, 1'b0, ma0, mb0);
      mn1 = ref_map(sym, 1'b1, ma1, mb1);
      if (sym_valid && rdy0) begin
        if (mn0 > 0) exp0.push_back(ma0);
        if (mn0 > 1) exp0.push_back(mb0);
      end
      if (sym_valid && rdy1) begin
        if (mn1 > 0) exp1.push_back(ma1);
        if (mn1 > 1) exp1.push_back(mb1);
      end
    end
  end

  task automatic clear_q();
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy0 && !busy1) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sym = '0; sym_valid = 1'b0; char_ready = 1'b0;
    #1;
    n_chk++; if (cv0 !== 1'b0 || cv1 !== 1'b0) $display("FAIL reset_valid: %b/%b exp 0", cv0, cv1); else n_pass++;
    n_chk++; if (chr0 !== 8'h00 || chr1 !== 8'h00) $display("FAIL reset_char: %h/%h exp 00", chr0, chr1); else n_pass++;
    n_chk++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) $display("FAIL reset_ready: %b/%b exp 1", rdy0, rdy1); else n_pass++;
    n_chk++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_busy: %b/%b exp 0", busy0, busy1); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_q();
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to, ok;
    char_ready = 1'b1;
    sym = 5'h11; sym_valid = 1'b1;
    @(negedge clk);
    n_chk++; if (cv0 !== 1'b0) $display("FAIL basic_latency_early: valid=%b exp 0", cv0); else n_pass++;
    sym = 5'h1B;
    @(negedge clk);
    n_chk++; if (cv0 !== 1'b1 || chr0 !== 8'h31) $display("FAIL basic_b0: valid=%b char=%h exp 1/31", cv0, chr0); else n_pass++;
    sym = 5'h12;
    @(negedge clk);
    n_chk++; if (cv0 !== 1'b1 || chr0 !== 8'h2B) $display("FAIL basic_b1: valid=%b char=%h exp 1/2b", cv0, chr0); else n_pass++;
    sym_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (cv0 !== 1'b1 || chr0 !== 8'h32) $display("FAIL basic_b2: valid=%b char=%h exp 1/32", cv0, chr0); else n_pass++;
    wait_idle(to);
    n_chk++; if (to || busy0 !== 1'b0) $display("FAIL basic_idle: busy=%b timeout=%0d exp idle", busy0, to); else n_pass++;
    ok = (got0.size() == exp0.size()) && (got1.size() == exp1.size());
    foreach (exp0[i]) if (ok && got0[i] !== exp0[i]) ok = 1'b0;
    foreach (exp1[i]) if (ok && got1[i] !== exp1[i]) ok = 1'b0;
    n_chk++; if (!ok) $display("FAIL basic_stream: got %0d/%0d bytes exp %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); else n_pass++;
    clear_q();
  endtask

  task automatic test_enter();
    bit to;
    char_ready = 1'b1;
    sym = 5'h0D; sym_valid = 1'b1;
    @(negedge clk);
    sym = 5'h10;
    @(negedge clk);
    sym_valid = 1'b0;
    n_chk++; if (cv0 !== 1'b1 || chr0 !== 8'h0D) $display("FAIL enter_cr: valid=%b char=%h exp 1/0d", cv0, chr0); else n_pass++;
    @(negedge clk);
    n_chk++; if (cv0 !== 1'b1 || chr0 !== 8'h0A) $display("FAIL enter_lf: valid=%b char=%h exp 1/0a", cv0, chr0); else n_pass++;
    @(negedge clk);
    n_chk++; if (cv0 !== 1'b1 || chr0 !== 8'h30) $display("FAIL enter_next: valid=%b char=%h exp 1/30", cv0, chr0); else n_pass++;
    wait_idle(to);
    n_chk++; if (to || got0.size() != 3 || got1.size() != 3) $display("FAIL enter_count: got %0d/%0d bytes exp 3/3", got0.size(), got1.size()); else n_pass++;
    clear_q();
  endtask

  task automatic test_backpressure();
    bit to, ok;
    logic [7:0] held;
    char_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sym = 5'($urandom_range(16, 30)); sym_valid = 1'b1;
      @(negedge clk);
      if (i == 7) begin
        n_chk++; if (rdy0 !== 1'b1) $display("FAIL bp_ready_at_7: ready=%b exp 1", rdy0); else n_pass++;
      end
    end
    n_chk++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) $display("FAIL bp_ready_full: ready=%b/%b exp 0", rdy0, rdy1); else n_pass++;
    held = chr0;
    n_chk++; if (cv0 !== 1'b1 || held !== exp0[0]) $display("FAIL bp_first: valid=%b char=%h exp 1/%h", cv0, held, exp0[0]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      sym = 5'($urandom_range(16, 30));
      @(negedge clk);
      n_chk++; if (cv0 !== 1'b1 || chr0 !== held) $display("FAIL bp_stable: valid=%b char=%h exp 1/%h", cv0, chr0, held); else n_pass++;
    end
    // Full with a pop in the same cycle: the offered symbol must not enter.
    char_ready = 1'b1; sym = 5'h15; sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    n_chk++; if (rdy0 !== 1'b1) $display("FAIL bp_full_pop: ready=%b exp 1", rdy0); else n_pass++;
    wait_idle(to);
    ok = !to && (got0.size() == 9) && (got0.size() == exp0.size()) && (got1.size() == exp1.size());
    foreach (exp0[i]) if (ok && got0[i] !== exp0[i]) ok = 1'b0;
    foreach (exp1[i]) if (ok && got1[i] !== exp1[i]) ok = 1'b0;
    n_chk++; if (!ok) $display("FAIL bp_drain: got %0d/%0d bytes exp %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); else n_pass++;
    clear_q();
  endtask

  task automatic test_push_pop_at_depth_minus_one();
    bit to, ok;
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sym = 5'($urandom_range(16, 25)); sym_valid = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (rdy0 !== 1'b1) $display("FAIL pp_pre: ready=%b exp 1", rdy0); else n_pass++;
    char_ready = 1'b1; sym = 5'h1C;
    @(negedge clk);
    sym_valid = 1'b0;
    n_chk++; if (rdy0 !== 1'b1) $display("FAIL pp_same_cycle: ready=%b exp 1", rdy0); else n_pass++;
    wait_idle(to);
    ok = !to && (got0.size() == 9) && (got0.size() == exp0.size());
    foreach (exp0[i]) if (ok && got0[i] !== exp0[i]) ok = 1'b0;
    n_chk++; if (!ok) $display("FAIL pp_drain: got %0d bytes exp %0d", got0.size(), exp0.size()); else n_pass++;
    clear_q();
  endtask

  task automatic test_invalid();
    bit to;
    char_ready = 1'b1;
    sym = 5'h1F; sym_valid = 1'b1;
    @(negedge clk);
    sym = 5'h05;
    @(negedge clk);
    sym = 5'h17;
    @(negedge clk);
    sym_valid = 1'b0;
    wait_idle(to);
    n_chk++;
    if (to || got0.size() != 3) $display("FAIL inv_keep_count: got %0d bytes exp 3", got0.size());
    else if (got0[0] !== 8'h3F || got0[1] !== 8'h3F || got0[2] !== 8'h37)
      $display("FAIL inv_keep_bytes: got %h %h %h exp 3f 3f 37", got0[0], got0[1], got0[2]);
    else n_pass++;
    n_chk++;
    if (got1.size() != 1) $display("FAIL inv_drop_count: got %0d bytes exp 1", got1.size());
    else if (got1[0] !== 8'h37) $display("FAIL inv_drop_byte: got %h exp 37", got1[0]);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_random();
    bit to, ok;
    logic pv0, pv1, pr;
    logic [7:0] pc0, pc1;
    pv0 = 1'b0; pv1 = 1'b0; pr = 1'b1; pc0 = '0; pc1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (pv0 && !pr) begin
        n_chk++; if (cv0 !== 1'b1 || chr0 !== pc0) $display("FAIL rnd_stable0: valid=%b char=%h exp 1/%h", cv0, chr0, pc0); else n_pass++;
      end
      if (pv1 && !pr) begin
        n_chk++; if (cv1 !== 1'b1 || chr1 !== pc1) $display("FAIL rnd_stable1: valid=%b char=%h exp 1/%h", cv1, chr1, pc1); else n_pass++;
      end
      sym        = 5'($urandom_range(0, 31));
      sym_valid  = ($urandom_range(0, 2) != 0);
      char_ready = ($urandom_range(0, 3) != 0);
      pv0 = cv0; pv1 = cv1; pc0 = chr0; pc1 = chr1; pr = char_ready;
      @(negedge clk);
    end
    sym_valid = 1'b0; char_ready = 1'b1;
    wait_idle(to);
    ok = !to && (got0.size() == exp0.size()) && (got1.size() == exp1.size());
    foreach (exp0[i]) if (ok && got0[i] !== exp0[i]) ok = 1'b0;
    foreach (exp1[i]) if (ok && got1[i] !== exp1[i]) ok = 1'b0;
    n_chk++; if (!ok) $display("FAIL rnd_stream: got %0d/%0d bytes exp %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); else n_pass++;
    clear_q();
  endtask

  task automatic test_reset_mid();
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sym = 5'($urandom_range(16, 25)); sym_valid = 1'b1;
      @(negedge clk);
    end
    sym_valid = 1'b0;
    n_chk++; if (cv0 !== 1'b1 || busy0 !== 1'b1) $display("FAIL rst_pre: valid=%b busy=%b exp 1/1", cv0, busy0); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (cv0 !== 1'b0 || cv1 !== 1'b0) $display("FAIL rst_async_valid: %b/%b exp 0", cv0, cv1); else n_pass++;
    n_chk++; if (chr0 !== 8'h00 || chr1 !== 8'h00) $display("FAIL rst_async_char: %h/%h exp 00", chr0, chr1); else n_pass++;
    n_chk++; if (rdy0 !== 1'b1 || busy0 !== 1'b0) $display("FAIL rst_async_fifo: ready=%b busy=%b exp 1/0", rdy0, busy0); else n_pass++;
    clear_q();
    @(negedge clk);
    rst = 1'b0; char_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++; if (got0.size() != 0 || got1.size() != 0 || cv0 !== 1'b0) $display("FAIL rst_stale: got %0d/%0d bytes valid=%b exp none", got0.size(), got1.size(), cv0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enter();
    test_backpressure();
    test_push_pop_at_depth_minus_one();
    test_invalid();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dau_sym_to_ascii_tx.md
Name: dau_sym_to_ascii_tx

Overview:
- Return path from the calculator core to the serial terminal. Inverse of the ASCII-to-DAU-symbol mapping.
- Accepts DAU symbols over a valid/ready handshake and buffers them in a small FIFO.
- Converts each symbol to ASCII and presents bytes to the UART transmitter over a second valid/ready handshake.
- A CR symbol is expanded to the two bytes CR, LF.

Parameters:
- FIFO_DEPTH, 8, symbol FIFO entries; power of two, minimum 2.
- DROP_INVALID, 0, 1 = silently discard unmapped symbols; 0 = emit '?' (8'h3F) for them.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_sym  input  `DAU_SYM_WIDTH (5)  DAU symbol from the core.
- i_sym_valid  input  1  i_sym is valid.
- o_sym_ready  output  1  FIFO can accept a symbol; equals (count != FIFO_DEPTH).
- o_char  output  8  ASCII byte to the UART TX; registered.
- o_char_valid  output  1  o_char is valid; registered.
- i_char_ready  input  1  UART TX accepts o_char this cycle.
- o_busy  output  1  FIFO non-empty or o_char_valid high.

Behaviour:
- Reset (asynchronous): FIFO pointers and count = 0, FSM = IDLE, o_char = 8'h00, o_char_valid = 0. All pending data is lost. Reset is legal mid-transfer; the UART must see o_char_valid drop immediately.
- Symbol map (from dau_symbols.vh):
  - 5'h10..5'h19 -> 8'h30..8'h39
  - 5'h0D (ENTER) -> 8'h0D then 8'h0A
  - 5'h02 (space) -> 8'h20
  - 5'h07 -> 8'h72 'r'
  - `DAU_SYM_MUL (5'h1A) -> 8'h2A
  - 5'h1B -> 8'h2B
  - 5'h1C -> 8'h2C
  - 5'h1D -> 8'h2D
  - `DAU_SYM_DIV (5'h1E) -> 8'h2F
  - All other codes, including `DAU_SYM_INVALID (5'h1F), are invalid; handling is set by DROP_INVALID.
- Input side: push on (i_sym_valid && o_sym_ready).
  - o_sym_ready depends only on count. When full, no push occurs even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
- Output handshake: transfer on (o_char_valid && i_char_ready).
  - While o_char_valid = 1 and i_char_ready = 0, o_char must stay stable.
  - o_char_valid never drops without a transfer, except on reset.
- FSM states:
  - IDLE: o_char_valid = 0. If the FIFO is non-empty: pop the head, load o_char with the mapped byte, go to SEND.
  - SEND: on transfer:
    - If the current symbol was ENTER: load 8'h0A and go to SEND_LF.
    - Else if the FIFO is non-empty: pop and load the next byte, stay in SEND.
    - Else: go to IDLE.
  - SEND_LF: on transfer, pop and load the next byte if the FIFO is non-empty (go to SEND), else go to IDLE.
  - DROP_INVALID = 1: a popped invalid symbol is consumed without loading o_char. The FSM goes to IDLE and the next pop happens on the following edge. A dropped symbol costs one cycle and is never presented.
- Timing:
  - Latency: symbol pushed at edge k into an empty, idle block gives o_char_valid = 1 after edge k+1.
  - Throughput: 1 byte/cycle with i_char_ready held high. ENTER occupies 2 output cycles.
- o_busy is combinational from count and o_char_valid.

Decomposition:
- Shared header dau_symbols.vh: `DAU_SYM_WIDTH, `DAU_SYM_MUL, `DAU_SYM_DIV, `DAU_SYM_INVALID. Add `DAU_SYM_ENTER (5'h0D) and ASCII constants CR/LF/'?'.
- Sub-module dau_sym_to_ascii_char (combinational): symbol -> {is_valid, byte}. Instantiated on the FIFO head.
- FIFO and FSM are inline.

Test Plan:
- Reset, then push 5'h11, 5'h1B, 5'h12 with i_char_ready = 1 -> bytes 8'h31, 8'h2B, 8'h32 on consecutive cycles. First valid appears 2 edges after the first push; o_busy is low afterwards.
- Push 5'h0D, then 5'h10 -> bytes 8'h0D, 8'h0A, 8'h30; LF is presented the cycle after CR is accepted.
- Hold i_char_ready = 0 and push 9 symbols with FIFO_DEPTH = 8:
  - o_sym_ready falls once 8 entries are stored (first byte already in the output register).
  - o_char stays stable while stalled.
  - Releasing ready drains all bytes in order with no loss or duplication.
- Push 5'h1F and 5'h05 with DROP_INVALID = 0 -> two bytes 8'h3F. Repeat with DROP_INVALID = 1 -> no bytes; the following 5'h17 yields 8'h37.
- Push a symbol and pop one in the same cycle while at FIFO_DEPTH-1 entries -> count unchanged, o_sym_ready stays 1. At full, a simultaneous pop does not accept the input.
- Assert i_rst asynchronously while o_char_valid = 1 with FIFO entries pending -> o_char_valid = 0 and o_char = 8'h00 immediately, o_sym_ready = 1. No stale bytes appear after reset release.
